// File: rtl/cpu_bus_sequencer.sv
// M-cycle/T-cycle sequencer and registered system-bus master for the SM83 core.
// Requests are captured at T0. Slow targets stretch the last T-cycle via mem_ready, bounded by MAX_WAIT.
module cpu_bus_sequencer #(
  parameter int T_PER_M    = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WAIT   = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  input  logic                          req_write,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic [DATA_WIDTH-1:0]         req_wdata,
  input  logic                          halt,
  output logic [$clog2(T_PER_M)-1:0]    t_cycle,
  output logic                          clk_phi,
  output logic                          m_start,
  output logic                          m_commit,
  output logic                          waiting,
  output logic                          bus_error,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic                          mem_enable,
  output logic                          mem_write,
  output logic [DATA_WIDTH-1:0]         mem_data_out,
  input  logic [DATA_WIDTH-1:0]         mem_data_in,
  input  logic                          mem_ready
);
  localparam int TW = $clog2(T_PER_M);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(T_PER_M - 1);
  localparam logic [TW-1:0] T_HALF = TW'(T_PER_M / 2);
  localparam logic [WW-1:0] W_MAX  = WW'(MAX_WAIT);

  typedef enum logic [1:0] {RUN, WAIT, HALT} state_t;
  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic          at_last, timeout;

  assign at_last   = (t_cycle == T_LAST);
  assign timeout   = (state == WAIT) && (wait_cnt == W_MAX) && !mem_ready;
  assign bus_error = timeout;
  assign m_start   = (state == RUN) && (t_cycle == '0);
  assign waiting   = (state == WAIT);
  assign clk_phi   = (t_cycle < T_HALF);

  // mem_ready only matters once an access is actually on the bus
  always_comb begin
    m_commit = 1'b0;
    if (state == RUN && at_last) m_commit = !mem_enable || mem_ready;
    else if (state == WAIT)      m_commit = mem_ready || (wait_cnt == W_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      t_cycle      <= '0;
      wait_cnt     <= '0;
      rdata        <= '0;
      mem_addr     <= '0;
      mem_enable   <= 1'b0;
      mem_write    <= 1'b0;
      mem_data_out <= '0;
    end else if (m_commit) begin
      t_cycle    <= '0;
      wait_cnt   <= '0;
      mem_enable <= 1'b0;
      mem_write  <= 1'b0;
      state      <= halt ? HALT : RUN;
      // a timed-out read returns open-bus all-ones
      if (mem_enable && !mem_write) rdata <= timeout ? '1 : mem_data_in;
    end else begin
      case (state)
        RUN: begin
          if (at_last) begin
            state    <= WAIT;
            wait_cnt <= WW'(1);
          end else begin
            t_cycle <= t_cycle + 1'b1;
            if (m_start && req_valid) begin
              mem_addr     <= req_addr;
              mem_write    <= req_write;
              mem_data_out <= req_wdata;
              mem_enable   <= 1'b1;
            end
          end
        end
        WAIT:    wait_cnt <= wait_cnt + 1'b1;
        HALT:    if (!halt) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_bus_sequencer.sv
// Randomized bench for cpu_bus_sequencer: each M-cycle is described by its request, ready delay and halt
// length. Expected per-clock outputs are derived from those numbers.
module tb_cpu_bus_sequencer;
  localparam int TPM  = 4;
  localparam int MAXW = 3;

  logic        clk = 0, reset = 1;
  logic        req_valid = 0, req_write = 0, halt = 0, mem_ready = 0;
  logic [15:0] req_addr = 0;
  logic [7:0]  req_wdata = 0, mem_data_in = 0;
  logic [1:0]  t_cycle;
  logic        clk_phi, m_start, m_commit, waiting, bus_error, mem_enable, mem_write;
  logic [7:0]  rdata, mem_data_out;
  logic [15:0] mem_addr;

  logic [2:0]  t8;
  logic        phi8, ms8, mc8, w8, be8, me8, mw8;
  logic [7:0]  rd8, mdo8;
  logic [15:0] ma8;

  int n_chk = 0, n_fail = 0;
  logic [7:0]  exp_rdata = 0, last_wdata = 0;
  logic [15:0] last_addr = 0;

  always #5 clk = ~clk;

  cpu_bus_sequencer #(.T_PER_M(TPM), .ADDR_WIDTH(16), .DATA_WIDTH(8), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .halt(halt), .t_cycle(t_cycle), .clk_phi(clk_phi), .m_start(m_start),
    .m_commit(m_commit), .waiting(waiting), .bus_error(bus_error), .rdata(rdata), .mem_addr(mem_addr),
    .mem_enable(mem_enable), .mem_write(mem_write), .mem_data_out(mem_data_out),
    .mem_data_in(mem_data_in), .mem_ready(mem_ready));

  // idle 8-clock build, only its counter and phase output are checked
  cpu_bus_sequencer #(.T_PER_M(8), .ADDR_WIDTH(16), .DATA_WIDTH(8), .MAX_WAIT(15)) dut8 (
    .clk(clk), .reset(reset), .req_valid(1'b0), .req_write(1'b0), .req_addr(16'h0),
    .req_wdata(8'h0), .halt(1'b0), .t_cycle(t8), .clk_phi(phi8), .m_start(ms8),
    .m_commit(mc8), .waiting(w8), .bus_error(be8), .rdata(rd8), .mem_addr(ma8),
    .mem_enable(me8), .mem_write(mw8), .mem_data_out(mdo8),
    .mem_data_in(8'h0), .mem_ready(1'b0));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One M-cycle: d = clocks mem_ready stays low from the last T-cycle on; h/hl = halt at commit and its length.
  task automatic mcycle(input bit v, input bit w, input logic [15:0] a, input logic [7:0] wd,
                        input int d, input int din_sel, input bit h, input int hl);
    int extra, tc;
    bit err;
    logic [7:0] din;
    extra = v ? ((d < MAXW) ? d : MAXW) : 0;
    err   = v && (d > MAXW);
    din   = 8'h0;
    for (int k = 0; k < TPM + extra; k++) begin
      int j;
      j = k - (TPM - 1);
      tc = (k < TPM) ? k : TPM - 1;
      @(negedge clk);
      reset       = 0;
      req_valid   = (k == 0) ? v  : 1'($urandom);
      req_write   = (k == 0) ? w  : 1'($urandom);
      req_addr    = (k == 0) ? a  : 16'($urandom);
      req_wdata   = (k == 0) ? wd : 8'($urandom);
      halt        = (j == extra) ? h : 1'($urandom);
      din         = (din_sel >= 0 && j == extra) ? 8'(din_sel) : 8'($urandom);
      mem_data_in = din;
      mem_ready   = (v && j >= 0) ? (j >= d) : 1'($urandom);
      #1;
      chk("t_cycle", 32'(t_cycle), tc);
      chk("clk_phi", clk_phi, tc < TPM / 2);
      chk("m_start", m_start, k == 0);
      chk("m_commit", m_commit, j == extra);
      chk("bus_error", bus_error, (j == extra) && err);
      chk("waiting", waiting, j > 0);
      chk("rdata", rdata, exp_rdata);
      chk("mem_enable", mem_enable, (k > 0) && v);
      chk("mem_write", mem_write, (k > 0) && v && w);
      chk("mem_addr", mem_addr, (k > 0 && v) ? a : last_addr);
      chk("mem_data_out", mem_data_out, (k > 0 && v) ? wd : last_wdata);
    end
    if (v) begin
      last_addr  = a;
      last_wdata = wd;
      if (!w) exp_rdata = err ? 8'hFF : din;
    end
    if (h) begin
      for (int i = 0; i <= hl; i++) begin
        @(negedge clk);
        halt      = (i < hl);
        req_valid = 1'($urandom);
        req_addr  = 16'($urandom);
        mem_ready = 1'($urandom);
        #1;
        chk("halt_t_cycle", 32'(t_cycle), 0);
        chk("halt_m_start", m_start, 0);
        chk("halt_m_commit", m_commit, 0);
        chk("halt_mem_enable", mem_enable, 0);
        chk("halt_clk_phi", clk_phi, 1);
        chk("halt_waiting", waiting, 0);
      end
    end
  endtask

  initial begin
    wait (reset == 1'b0);
    for (int i = 0; i < 24; i++) begin
      #1;
      chk("t8_t_cycle", 32'(t8), i % 8);
      chk("t8_clk_phi", phi8, (i % 8) < 4);
      @(negedge clk);
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_t_cycle", 32'(t_cycle), 0);
    chk("rst_mem_enable", mem_enable, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data_out", mem_data_out, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_m_commit", m_commit, 0);
    chk("rst_waiting", waiting, 0);

    repeat (4) mcycle(0, 0, 16'h0, 8'h0, 0, -1, 0, 0);
    mcycle(1, 0, 16'hC123, 8'h00, 0, 8'h5A, 0, 0);
    mcycle(1, 1, 16'hFF40, 8'h91, 2, -1, 0, 0);
    mcycle(0, 0, 16'h0, 8'h0, 0, -1, 0, 0);
    chk("read_rdata_5a", rdata, 8'h5A);
    mcycle(1, 0, 16'h8001, 8'h00, 10, -1, 0, 0);
    mcycle(0, 0, 16'h0, 8'h0, 0, -1, 1, 5);
    chk("timeout_rdata_ff", rdata, 8'hFF);
    mcycle(1, 0, 16'h1000, 8'h00, MAXW, -1, 1, 0);

    // stalled read aborted by reset in its second wait clock
    for (int k = 0; k < TPM + 1; k++) begin
      @(negedge clk);
      halt = 0; req_valid = (k == 0); req_write = 0; req_addr = 16'h1234; mem_ready = 0;
    end
    @(negedge clk);
    reset = 1; mem_ready = 0;
    #1;
    chk("pre_rst_waiting", waiting, 1);
    chk("pre_rst_m_commit", m_commit, 0);
    @(negedge clk);
    #1;
    chk("post_rst_t_cycle", 32'(t_cycle), 0);
    chk("post_rst_mem_enable", mem_enable, 0);
    chk("post_rst_waiting", waiting, 0);
    chk("post_rst_m_commit", m_commit, 0);
    chk("post_rst_mem_addr", mem_addr, 0);
    chk("post_rst_rdata", rdata, 0);
    exp_rdata = 0; last_addr = 0; last_wdata = 0;

    for (int n = 0; n < 150; n++)
      mcycle(1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom),
             int'($urandom_range(0, MAXW + 2)), -1,
             $urandom_range(0, 5) == 0, int'($urandom_range(0, 4)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
